multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
//  Multi-cycle RV32I control FSM. Successor to the single-cycle opcode decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB over one shared memory port with a req/ready handshake.
//  Adds a memory-wait timeout, a sticky fault state and a retired-instruction counter.
//  Sits between the instruction register / ALU flags and the datapath muxes, register file and PC.
// PARAMETERS
//  CNT_W        32          width of instret counter
//  MEM_TIMEOUT  16          max wait cycles for mem_ready before FAULT; 0 = no timeout
//  HALT_OPCODE  7'b1111111  opcode decoded as HALT (only with CTRL_HALT_EN)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      synchronous, active-high
//  Opcode       in   7      IR[6:0], valid from DECODE onward
//  BranchTaken  in   1      branch compare result, sampled in EXEC
//  mem_ready    in   1      memory ack for the current MemReq
//  MemReq       out  1      memory access request
//  MemWe        out  1      write strobe; valid only with MemReq
//  AddrSrc      out  1      0: address = PC; 1: address = ALU result
//  IRWrite      out  1      load IR and hold MDR
//  ALUSrc       out  1      0: rs2; 1: immediate
//  ALUOp        out  2      00: add (ld/st/jalr); 01: branch; 10: R/I funct decode
//  RegWrite     out  1      register file write enable
//  RWsel        out  2      rd source. 00: ALU; 01: PC+4; 10: memory data
//  PCWrite      out  1      PC update strobe, one cycle per retired instruction
//  PCSrc        out  2      00: PC+4; 01: PC+imm (branch/jal); 10: ALU (jalr, LSB cleared)
//  Halted       out  1      sticky, HALT reached
//  Fault        out  1      sticky, illegal opcode or memory timeout
//  instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - States: FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
//    Outputs are a Moore decode of state, plus BranchTaken/mem_ready qualifiers.
//  - While reset is high, every control output is forced to 0. At the reset edge:
//    state=FETCH, instret=0, wait counter=0, Halted=0, Fault=0.
//  - FETCH: MemReq=1, AddrSrc=0. On mem_ready: IRWrite=1 in the same cycle, then go to DECODE.
//  - DECODE: decodes R(0110011), I(0010011), LOAD(0000011), S(0100011), B(1100011),
//    JAL(1101111), JALR(1100111) and goes to EXEC. Any other opcode goes to FAULT.
//  - EXEC:
//    - ALUSrc=1 for I/LOAD/S/JALR; ALUOp as listed under PORTS.
//    - R/I/JAL/JALR go to WB. LOAD/S go to MEM.
//    - B: PCWrite=1, PCSrc=BranchTaken?01:00, retire, go to FETCH.
//  - MEM: MemReq=1, AddrSrc=1, MemWe=(S). On mem_ready:
//    - S: PCWrite=1, PCSrc=00, retire, go to FETCH.
//    - LOAD: go to WB.
//  - WB: RegWrite=1, PCWrite=1, retire, go to FETCH.
//    - RWsel: 00 for R/I; 01 for JAL/JALR; 10 for LOAD.
//    - PCSrc: 00 for R/I/LOAD; 01 for JAL; 10 for JALR.
//  - Latency with mem_ready already high: B=3; R/I/S/JAL/JALR=4; LOAD=5 cycles.
//  - Wait counter:
//    - Counts consecutive cycles in FETCH/MEM with MemReq=1 and mem_ready=0.
//    - Clears on mem_ready or on a state change.
//    - When it reaches MEM_TIMEOUT (MEM_TIMEOUT>0), the next state is FAULT.
//      A mem_ready in that same cycle wins: no fault.
//  - FAULT and HALT are absorbing: all strobes are 0 and only reset exits.
//    Fault=1 in FAULT; Halted=1 in HALT.
//  - instret: +1 on every retire (a PCWrite cycle). Saturates at all-ones; no wrap.
//  - Reset mid-access drops MemReq the same cycle. The aborted instruction is not counted.
//  - mem_ready outside FETCH/MEM is ignored.
// CONFIGURATION
//  - CTRL_HALT_EN defined: Opcode==HALT_OPCODE in DECODE goes to HALT. No retire, no PCWrite.
//  - CTRL_HALT_EN undefined: HALT_OPCODE is illegal and goes to FAULT. Halted is tied to 0.
// TESTING
//  - Reset, then add (0110011) with mem_ready=1:
//    states F,D,E,W; RegWrite=1 and PCWrite=1 in cycle 4; instret=1.
//  - lw (0000011) with mem_ready low for 3 cycles in MEM:
//    MemReq=1, AddrSrc=1 is held; WB on cycle 8; RWsel=10.
//  - beq, BranchTaken=1: PCSrc=01, PCWrite=1 in EXEC; back to FETCH after 3 cycles.
//    BranchTaken=0: PCSrc=00.
//  - Opcode 0000000 -> FAULT; Fault=1 held for 20 cycles; instret unchanged.
//  - mem_ready held 0 in FETCH, MEM_TIMEOUT=16: FAULT after 16 wait cycles.
//    Rerun with ready at wait 16: no fault.
//  - Opcode 1111111: with CTRL_HALT_EN -> Halted=1. Without -> Fault=1.
//    Then assert reset mid-MEM of a sw: MemReq=0 that cycle, instret=0 after.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB over one req/ready memory port,
// with memory-wait timeout, sticky FAULT/HALT and a saturating retire counter. Optional HALT via CTRL_HALT_EN.
module multicycle_controller #(
  parameter int         CNT_W       = 32,
  parameter int         MEM_TIMEOUT = 16,
  parameter logic [6:0] HALT_OPCODE = 7'b1111111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       Opcode,
  input  logic             BranchTaken,
  input  logic             mem_ready,
  output logic             MemReq,
  output logic             MemWe,
  output logic             AddrSrc,
  output logic             IRWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUOp,
  output logic             RegWrite,
  output logic [1:0]       RWsel,
  output logic             PCWrite,
  output logic [1:0]       PCSrc,
  output logic             Halted,
  output logic             Fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  localparam logic [2:0] CL_R    = 3'd0;
  localparam logic [2:0] CL_I    = 3'd1;
  localparam logic [2:0] CL_LOAD = 3'd2;
  localparam logic [2:0] CL_S    = 3'd3;
  localparam logic [2:0] CL_B    = 3'd4;
  localparam logic [2:0] CL_JAL  = 3'd5;
  localparam logic [2:0] CL_JALR = 3'd6;

`ifdef CTRL_HALT_EN
  localparam logic [2:0] HALT_DEST = S_HALT;
`else
  localparam logic [2:0] HALT_DEST = S_FAULT;
`endif

  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [2:0]        state_reg, state_next;
  logic [2:0]        class_reg, class_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [CNT_W-1:0]  instret_reg;
  logic              timeout_hit;

  logic       mem_req_c, mem_we_c, addr_src_c, ir_write_c, alu_src_c;
  logic       reg_write_c, pc_write_c;
  logic [1:0] alu_op_c, rw_sel_c, pc_src_c;

  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_reg == WAIT_LIMIT);

  always_comb begin
    state_next  = state_reg;
    class_next  = class_reg;
    wait_next   = '0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_src_c  = 1'b0;
    ir_write_c  = 1'b0;
    alu_src_c   = 1'b0;
    alu_op_c    = 2'b00;
    reg_write_c = 1'b0;
    rw_sel_c    = 2'b00;
    pc_write_c  = 1'b0;
    pc_src_c    = 2'b00;
    case (state_reg)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end else begin
          wait_next = (wait_reg == '1) ? wait_reg : wait_reg + 1'b1;
        end
      end
      S_DECODE: begin
        state_next = S_EXEC;
        case (Opcode)
          7'b0110011: class_next = CL_R;
          7'b0010011: class_next = CL_I;
          7'b0000011: class_next = CL_LOAD;
          7'b0100011: class_next = CL_S;
          7'b1100011: class_next = CL_B;
          7'b1101111: class_next = CL_JAL;
          7'b1100111: class_next = CL_JALR;
          default:    state_next = (Opcode == HALT_OPCODE) ? HALT_DEST : S_FAULT;
        endcase
      end
      S_EXEC: begin
        state_next = S_WB;
        case (class_reg)
          CL_R: alu_op_c = 2'b10;
          CL_I: begin
            alu_src_c = 1'b1;
            alu_op_c  = 2'b10;
          end
          CL_LOAD, CL_S: begin
            alu_src_c  = 1'b1;
            state_next = S_MEM;
          end
          CL_B: begin
            alu_op_c   = 2'b01;
            pc_write_c = 1'b1;
            pc_src_c   = BranchTaken ? 2'b01 : 2'b00;
            state_next = S_FETCH;
          end
          CL_JALR: alu_src_c = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_src_c = 1'b1;
        mem_we_c   = (class_reg == CL_S);
        if (mem_ready) begin
          if (class_reg == CL_S) begin
            pc_write_c = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end else if (timeout_hit) begin
          state_next = S_FAULT;
        end else begin
          wait_next = (wait_reg == '1) ? wait_reg : wait_reg + 1'b1;
        end
      end
      S_WB: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        state_next  = S_FETCH;
        case (class_reg)
          CL_LOAD: rw_sel_c = 2'b10;
          CL_JAL: begin
            rw_sel_c = 2'b01;
            pc_src_c = 2'b01;
          end
          CL_JALR: begin
            rw_sel_c = 2'b01;
            pc_src_c = 2'b10;
          end
          default: ;
        endcase
      end
      S_HALT, S_FAULT: ;
      default: state_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      class_reg   <= CL_R;
      wait_reg    <= '0;
      instret_reg <= '0;
    end else begin
      state_reg <= state_next;
      class_reg <= class_next;
      wait_reg  <= wait_next;
      // Every PCWrite cycle retires exactly one instruction; saturate rather than wrap.
      if (pc_write_c && (instret_reg != '1))
        instret_reg <= instret_reg + 1'b1;
    end
  end

  // Reset masks all strobes combinationally so an in-flight request drops immediately.
  assign MemReq   = !reset && mem_req_c;
  assign MemWe    = !reset && mem_we_c;
  assign AddrSrc  = !reset && addr_src_c;
  assign IRWrite  = !reset && ir_write_c;
  assign ALUSrc   = !reset && alu_src_c;
  assign ALUOp    = reset ? 2'b00 : alu_op_c;
  assign RegWrite = !reset && reg_write_c;
  assign RWsel    = reset ? 2'b00 : rw_sel_c;
  assign PCWrite  = !reset && pc_write_c;
  assign PCSrc    = reset ? 2'b00 : pc_src_c;
  assign Fault    = !reset && (state_reg == S_FAULT);
`ifdef CTRL_HALT_EN
  assign Halted   = !reset && (state_reg == S_HALT);
`else
  assign Halted   = 1'b0;
`endif
  assign instret  = instret_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller: a per-cycle table plus hand sequences
// for timeout, fault/halt stickiness, instret saturation and reset mid-access.
module tb_multicycle_controller;

  localparam int CW = 4;

  // Observed control bundle layout (bit 14 down to 0).
  localparam logic [14:0] C_NONE   = 15'h0000;
  localparam logic [14:0] C_MREQ   = 15'h4000;
  localparam logic [14:0] C_MWE    = 15'h2000;
  localparam logic [14:0] C_ASRC   = 15'h1000;
  localparam logic [14:0] C_IRW    = 15'h0800;
  localparam logic [14:0] C_ALUSRC = 15'h0400;
  localparam logic [14:0] AOP_BR   = 15'h0100;
  localparam logic [14:0] AOP_FN   = 15'h0200;
  localparam logic [14:0] C_REGW   = 15'h0080;
  localparam logic [14:0] RW_PC4   = 15'h0020;
  localparam logic [14:0] RW_MEM   = 15'h0040;
  localparam logic [14:0] C_PCW    = 15'h0010;
  localparam logic [14:0] PC_IMM   = 15'h0004;
  localparam logic [14:0] PC_ALU   = 15'h0008;
  localparam logic [14:0] C_HALT   = 15'h0002;
  localparam logic [14:0] C_FAULT  = 15'h0001;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BAD  = 7'b0000000;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  logic clk = 1'b0;
  logic reset, BranchTaken, mem_ready;
  logic [6:0] Opcode;
  logic MemReq, MemWe, AddrSrc, IRWrite, ALUSrc, RegWrite, PCWrite, Halted, Fault;
  logic [1:0] ALUOp, RWsel, PCSrc;
  logic [CW-1:0] instret;
  logic [14:0] ctrl_obs;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic          rst;
    logic [6:0]    op;
    logic          bt;
    logic          rdy;
    logic [14:0]   ctrl;
    logic [CW-1:0] cnt;
  } vec_t;
  vec_t vecs[$];

  multicycle_controller #(.CNT_W(CW), .MEM_TIMEOUT(16), .HALT_OPCODE(7'b1111111)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .BranchTaken(BranchTaken), .mem_ready(mem_ready),
    .MemReq(MemReq), .MemWe(MemWe), .AddrSrc(AddrSrc), .IRWrite(IRWrite), .ALUSrc(ALUSrc),
    .ALUOp(ALUOp), .RegWrite(RegWrite), .RWsel(RWsel), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .Halted(Halted), .Fault(Fault), .instret(instret)
  );

  always #5 clk = ~clk;

  assign ctrl_obs = {MemReq, MemWe, AddrSrc, IRWrite, ALUSrc, ALUOp, RegWrite, RWsel,
                     PCWrite, PCSrc, Halted, Fault};

  task automatic v(input logic r, input logic [6:0] op, input logic bt, input logic rdy,
                   input logic [14:0] ctrl, input logic [CW-1:0] cnt);
    vec_t e;
    e.rst = r; e.op = op; e.bt = bt; e.rdy = rdy; e.ctrl = ctrl; e.cnt = cnt;
    vecs.push_back(e);
  endtask

  // Drive inputs just after the falling edge, then sample 1 ns later (far from posedge).
  task automatic drive(input logic r, input logic [6:0] op, input logic bt, input logic rdy);
    @(negedge clk);
    reset = r; Opcode = op; BranchTaken = bt; mem_ready = rdy;
    #1;
  endtask

  task automatic chk_ctrl(input string nm, input logic [14:0] exp);
    n_cmp++;
    if (ctrl_obs !== exp) begin
      n_bad++;
      $display("FAIL %s: ctrl got %h expected %h", nm, ctrl_obs, exp);
    end
  endtask

  task automatic chk_cnt(input string nm, input logic [CW-1:0] exp);
    n_cmp++;
    if (instret !== exp) begin
      n_bad++;
      $display("FAIL %s: instret got %0d expected %0d", nm, instret, exp);
    end
  endtask

  task automatic do_reset();
    drive(1'b1, OP_R, 1'b0, 1'b0);
    drive(1'b1, OP_R, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; Opcode = OP_R; BranchTaken = 1'b0; mem_ready = 1'b0;

    // Per-cycle table: state at cycle start is implied by the sequence.
    v(1, OP_R,    0, 1, C_NONE, 0);
    v(0, OP_R,    0, 1, C_MREQ | C_IRW, 0);                 // add: F
    v(0, OP_R,    0, 0, C_NONE, 0);                         // D (ready ignored)
    v(0, OP_R,    0, 1, AOP_FN, 0);                         // E
    v(0, OP_R,    0, 1, C_REGW | C_PCW, 0);                 // W
    v(0, OP_I,    0, 1, C_MREQ | C_IRW, 1);                 // addi
    v(0, OP_I,    0, 1, C_NONE, 1);
    v(0, OP_I,    0, 1, C_ALUSRC | AOP_FN, 1);
    v(0, OP_I,    0, 1, C_REGW | C_PCW, 1);
    v(0, OP_B,    1, 1, C_MREQ | C_IRW, 2);                 // beq taken
    v(0, OP_B,    1, 1, C_NONE, 2);
    v(0, OP_B,    1, 1, AOP_BR | C_PCW | PC_IMM, 2);
    v(0, OP_B,    0, 1, C_MREQ | C_IRW, 3);                 // beq not taken
    v(0, OP_B,    0, 1, C_NONE, 3);
    v(0, OP_B,    0, 1, AOP_BR | C_PCW, 3);
    v(0, OP_JAL,  0, 1, C_MREQ | C_IRW, 4);                 // jal
    v(0, OP_JAL,  0, 1, C_NONE, 4);
    v(0, OP_JAL,  0, 1, C_NONE, 4);
    v(0, OP_JAL,  0, 1, C_REGW | RW_PC4 | C_PCW | PC_IMM, 4);
    v(0, OP_JALR, 0, 1, C_MREQ | C_IRW, 5);                 // jalr
    v(0, OP_JALR, 0, 1, C_NONE, 5);
    v(0, OP_JALR, 0, 1, C_ALUSRC, 5);
    v(0, OP_JALR, 0, 1, C_REGW | RW_PC4 | C_PCW | PC_ALU, 5);
    v(0, OP_S,    0, 1, C_MREQ | C_IRW, 6);                 // sw
    v(0, OP_S,    0, 1, C_NONE, 6);
    v(0, OP_S,    0, 1, C_ALUSRC, 6);
    v(0, OP_S,    0, 1, C_MREQ | C_MWE | C_ASRC | C_PCW, 6);
    v(0, OP_LD,   0, 1, C_MREQ | C_IRW, 7);                 // lw, 3 wait cycles in MEM
    v(0, OP_LD,   0, 1, C_NONE, 7);
    v(0, OP_LD,   0, 1, C_ALUSRC, 7);
    v(0, OP_LD,   0, 0, C_MREQ | C_ASRC, 7);
    v(0, OP_LD,   0, 0, C_MREQ | C_ASRC, 7);
    v(0, OP_LD,   0, 0, C_MREQ | C_ASRC, 7);
    v(0, OP_LD,   0, 1, C_MREQ | C_ASRC, 7);
    v(0, OP_LD,   0, 0, C_REGW | RW_MEM | C_PCW, 7);        // W on cycle 8
    v(0, OP_BAD,  0, 1, C_MREQ | C_IRW, 8);                 // illegal opcode
    v(0, OP_BAD,  0, 1, C_NONE, 8);
    v(0, OP_BAD,  0, 1, C_FAULT, 8);

    @(posedge clk);
    @(posedge clk);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].bt, vecs[i].rdy);
      $display("vec %0d rst=%b op=%b rdy=%b ctrl=%h instret=%0d",
               i, vecs[i].rst, vecs[i].op, vecs[i].rdy, ctrl_obs, instret);
      chk_ctrl($sformatf("vec%0d", i), vecs[i].ctrl);
      chk_cnt($sformatf("vec%0d", i), vecs[i].cnt);
    end

    // FAULT is absorbing regardless of inputs.
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, OP_R, k[0], k[1]);
      chk_ctrl("fault_hold", C_FAULT);
      chk_cnt("fault_hold", 4'd8);
    end
    $display("seq fault_hold done instret=%0d", instret);

    // Fetch timeout: 17 cycles of MemReq (wait 0..16), then FAULT.
    do_reset();
    for (int k = 0; k <= 16; k++) begin
      drive(1'b0, OP_R, 1'b0, 1'b0);
      chk_ctrl($sformatf("tmo_wait%0d", k), C_MREQ);
    end
    drive(1'b0, OP_R, 1'b0, 1'b0);
    chk_ctrl("tmo_fault", C_FAULT);
    $display("seq timeout done fault=%b", Fault);

    // Ready arriving at wait 16 wins over the timeout.
    do_reset();
    for (int k = 0; k < 16; k++) drive(1'b0, OP_R, 1'b0, 1'b0);
    drive(1'b0, OP_R, 1'b0, 1'b1);
    chk_ctrl("tmo_edge_fetch", C_MREQ | C_IRW);
    drive(1'b0, OP_R, 1'b0, 1'b0);
    chk_ctrl("tmo_edge_decode", C_NONE);
    drive(1'b0, OP_R, 1'b0, 1'b0);
    chk_ctrl("tmo_edge_exec", AOP_FN);
    $display("seq timeout_edge done fault=%b", Fault);

    // HALT opcode.
    do_reset();
    drive(1'b0, OP_HALT, 1'b0, 1'b1);
    drive(1'b0, OP_HALT, 1'b0, 1'b1);
    chk_ctrl("halt_decode", C_NONE);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, OP_HALT, 1'b0, 1'b1);
`ifdef CTRL_HALT_EN
      chk_ctrl("halt_state", C_HALT);
`else
      chk_ctrl("halt_state", C_FAULT);
`endif
      chk_cnt("halt_cnt", 4'd0);
    end
    $display("seq halt done halted=%b fault=%b", Halted, Fault);

    // Saturation: 17 branches with a 4-bit counter stop at 15.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b0, OP_B, 1'b0, 1'b1);
      chk_cnt($sformatf("sat_br%0d", k), (k > 15) ? 4'd15 : CW'(k));
      drive(1'b0, OP_B, 1'b0, 1'b1);
      drive(1'b0, OP_B, 1'b0, 1'b1);
    end
    drive(1'b0, OP_B, 1'b0, 1'b1);
    chk_cnt("sat_final", 4'd15);
    $display("seq saturate done instret=%0d", instret);

    // Reset during a store's MEM wait drops MemReq that cycle; nothing retires.
    drive(1'b1, OP_S, 1'b0, 1'b1);
    drive(1'b0, OP_S, 1'b0, 1'b1);
    drive(1'b0, OP_S, 1'b0, 1'b1);
    drive(1'b0, OP_S, 1'b0, 1'b1);
    drive(1'b0, OP_S, 1'b0, 1'b0);
    chk_ctrl("sw_mem_wait", C_MREQ | C_MWE | C_ASRC);
    drive(1'b1, OP_S, 1'b0, 1'b0);
    chk_ctrl("sw_reset_drop", C_NONE);
    drive(1'b0, OP_S, 1'b0, 1'b0);
    chk_ctrl("sw_after_reset", C_MREQ);
    chk_cnt("sw_after_reset", 4'd0);
    $display("seq reset_mid_mem done instret=%0d", instret);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
